mc_control_unit: RTL and testbench

- Multicycle control unit for the ARM-subset core. Sequences one shared ALU, one unified memory port and an external iterative multiplier across several cycles per instruction.
- Performs main and ALU decode internally (same Op/Funct/cmd encodings as the single-cycle core, including UMUL/SMUL).
- Holds the NZCV flags register and evaluates condition codes.
- Drives all datapath enables and muxes.

---
 rtl/mc_ctrl_pkg.sv | 81 ++++++++
 rtl/mc_control_unit_cond_check.sv | 37 +++
 rtl/mc_control_unit.sv | 169 ++++++++++++++++
 tb/tb_mc_control_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
// Contents: FSM state enum, ALU/result/source/immediate mux codes, data-processing
// cmd and condition-code encodings, and the ALU-control decode helper.
package mc_ctrl_pkg;

  localparam int unsigned ALU_W  = 3;
  localparam int unsigned RES_W  = 2;
  localparam int unsigned SRCB_W = 2;
  localparam int unsigned IMM_W  = 2;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned CMD_W  = 4;
  localparam int unsigned COND_W = 4;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, MULWAIT, ALUWB, BRANCH
  } state_t;

  localparam logic [ALU_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND  = 3'b010;
  localparam logic [ALU_W-1:0] ALU_ORR  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_UMUL = 3'b100;
  localparam logic [ALU_W-1:0] ALU_SMUL = 3'b101;

  localparam logic [RES_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [RES_W-1:0] RES_READDATA  = 2'b01;
  localparam logic [RES_W-1:0] RES_ALURESULT = 2'b10;

  localparam logic [SRCB_W-1:0] SRCB_RM   = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic [IMM_W-1:0] IMM_DP  = 2'b00;
  localparam logic [IMM_W-1:0] IMM_MEM = 2'b01;
  localparam logic [IMM_W-1:0] IMM_BR  = 2'b10;

  localparam logic [OP_W-1:0] OP_DP  = 2'b00;
  localparam logic [OP_W-1:0] OP_MEM = 2'b01;
  localparam logic [OP_W-1:0] OP_BR  = 2'b10;
  localparam logic [OP_W-1:0] OP_BAD = 2'b11;

  localparam logic [CMD_W-1:0] CMD_AND  = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_SUB  = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_ADD  = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_UMUL = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_ORR  = 4'b1100;
  localparam logic [CMD_W-1:0] CMD_SMUL = 4'b1110;

  localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE = 4'b0001;
  localparam logic [COND_W-1:0] COND_CS = 4'b0010;
  localparam logic [COND_W-1:0] COND_CC = 4'b0011;
  localparam logic [COND_W-1:0] COND_MI = 4'b0100;
  localparam logic [COND_W-1:0] COND_PL = 4'b0101;
  localparam logic [COND_W-1:0] COND_VS = 4'b0110;
  localparam logic [COND_W-1:0] COND_VC = 4'b0111;
  localparam logic [COND_W-1:0] COND_HI = 4'b1000;
  localparam logic [COND_W-1:0] COND_LS = 4'b1001;
  localparam logic [COND_W-1:0] COND_GE = 4'b1010;
  localparam logic [COND_W-1:0] COND_LT = 4'b1011;
  localparam logic [COND_W-1:0] COND_GT = 4'b1100;
  localparam logic [COND_W-1:0] COND_LE = 4'b1101;
  localparam logic [COND_W-1:0] COND_AL = 4'b1110;

  // Multiply codes exist only in register form; anything unrecognised falls back to ADD.
  function automatic logic [ALU_W-1:0] alu_decode(input logic [CMD_W-1:0] cmd, input logic imm);
    logic [ALU_W-1:0] r;
    r = ALU_ADD;
    case (cmd)
      CMD_ADD:  r = ALU_ADD;
      CMD_SUB:  r = ALU_SUB;
      CMD_AND:  r = ALU_AND;
      CMD_ORR:  r = ALU_ORR;
      CMD_UMUL: r = imm ? ALU_ADD : ALU_UMUL;
      CMD_SMUL: r = imm ? ALU_ADD : ALU_SMUL;
      default:  r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_control_unit_cond_check.sv
// Condition-code evaluator.
// Ports: cond (Instr[31:28]), nzcv (flags register) -> condex (1 = execute).
module mc_control_unit_cond_check
  import mc_ctrl_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [3:0]        nzcv,
  output logic              condex
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  // 1111 has no entry and evaluates false through the default.
  always_comb begin
    condex = 1'b0;
    case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~(c & ~z);
      COND_GE: condex = (n == v);
      COND_LT: condex = (n != v);
      COND_GT: condex = ~z & (n == v);
      COND_LE: condex = z | (n != v);
      COND_AL: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control unit: main/ALU decode, NZCV flags, condition check and the
// instruction-sequencing FSM with a watchdog on the external multiplier.
// Inputs: CLK, Reset (sync, active-high), Instr, ALUFlags {N,Z,C,V}, MulDone.
// Outputs: PCWrite, AdrSrc, MemW, IRWrite, RegW, ResultSrc, ALUSrcA, ALUSrcB,
//          ImmSrc, RegSrc, ALUControl, MulStart.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MUL_MAX_CYC = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [31:0]       Instr,
  input  logic [3:0]        ALUFlags,
  input  logic              MulDone,
  output logic              PCWrite,
  output logic              AdrSrc,
  output logic              MemW,
  output logic              IRWrite,
  output logic              RegW,
  output logic [RES_W-1:0]  ResultSrc,
  output logic              ALUSrcA,
  output logic [SRCB_W-1:0] ALUSrcB,
  output logic [IMM_W-1:0]  ImmSrc,
  output logic [1:0]        RegSrc,
  output logic [ALU_W-1:0]  ALUControl,
  output logic              MulStart
);

  localparam int unsigned CNT_W = (MUL_MAX_CYC > 1) ? $clog2(MUL_MAX_CYC) : 1;

  state_t           state, state_nxt;
  logic [3:0]       nzcv;
  logic [CNT_W-1:0] mul_cnt;
  logic             condex;

  logic [OP_W-1:0]  op;
  logic [CMD_W-1:0] cmd;
  logic             funct_i, sbit;
  logic             is_mul, mul_exit;
  logic [ALU_W-1:0] dp_alu;
  logic             flagw_nz, flagw_cv;
  logic             unused_instr;

  assign op      = Instr[27:26];
  assign funct_i = Instr[25];
  assign cmd     = Instr[24:21];
  assign sbit    = Instr[20];
  assign unused_instr = ^Instr[19:0];

  assign dp_alu   = alu_decode(cmd, funct_i);
  assign is_mul   = (op == OP_DP) && !funct_i && ((cmd == CMD_UMUL) || (cmd == CMD_SMUL));
  assign mul_exit = (state == MULWAIT) &&
                    (MulDone || (mul_cnt == CNT_W'(MUL_MAX_CYC - 1)));

  // Flags land on the last execute cycle; C/V only for arithmetic ops.
  assign flagw_nz = (op == OP_DP) && sbit &&
                    ((((state == EXECR) || (state == EXECI)) && !is_mul) || mul_exit);
  assign flagw_cv = flagw_nz && ((dp_alu == ALU_ADD) || (dp_alu == ALU_SUB));

  // Instruction-field decodes that bypass the state machine.
  assign ImmSrc = (op == OP_MEM) ? IMM_MEM : (op == OP_BR) ? IMM_BR : IMM_DP;
  assign RegSrc = {(op == OP_MEM) && !sbit, op == OP_BR};

  mc_control_unit_cond_check u_cond (
    .cond   (Instr[31:28]),
    .nzcv   (nzcv),
    .condex (condex)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Flags register and multiplier watchdog.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      nzcv    <= 4'b0000;
      mul_cnt <= '0;
    end else begin
      if (flagw_nz) nzcv[3:2] <= ALUFlags[3:2];
      if (flagw_cv) nzcv[1:0] <= ALUFlags[1:0];
      if (state == MULWAIT) mul_cnt <= mul_exit ? '0 : mul_cnt + CNT_W'(1);
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_nxt  = state;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemW       = 1'b0;
    IRWrite    = 1'b0;
    RegW       = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RM;
    ALUControl = ALU_ADD;
    MulStart   = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        state_nxt = DECODE;
      end
      DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (!condex || (op == OP_BAD)) state_nxt = FETCH;
        else if (op == OP_MEM)         state_nxt = MEMADR;
        else if (op == OP_BR)          state_nxt = BRANCH;
        else                           state_nxt = funct_i ? EXECI : EXECR;
      end
      MEMADR: begin
        ALUSrcB   = SRCB_IMM;
        state_nxt = sbit ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc    = 1'b1;
        state_nxt = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_READDATA;
        RegW      = 1'b1;
        state_nxt = FETCH;
      end
      MEMWR: begin
        AdrSrc    = 1'b1;
        MemW      = 1'b1;
        state_nxt = FETCH;
      end
      EXECR, EXECI: begin
        ALUSrcB    = (state == EXECI) ? SRCB_IMM : SRCB_RM;
        ALUControl = dp_alu;
        MulStart   = is_mul;
        state_nxt  = is_mul ? MULWAIT : ALUWB;
      end
      MULWAIT: begin
        ALUControl = dp_alu;
        if (mul_exit) state_nxt = ALUWB;
      end
      ALUWB: begin
        RegW      = 1'b1;
        state_nxt = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        PCWrite   = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
    // No architectural write may happen in a reset cycle.
    if (Reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegW     = 1'b0;
      MemW     = 1'b0;
      MulStart = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: the driver walks each instruction through
// its expected cycle sequence, pushing a masked output expectation per cycle; a
// negedge monitor pops and compares.
module tb_mc_control_unit;

  localparam int MUL_MAX = 32;
  localparam int PH_FETCH = 0, PH_DECODE = 1, PH_MEMADR = 2, PH_MEMRD = 3, PH_MEMWB = 4,
                 PH_MEMWR = 5, PH_EXECR = 6, PH_EXECI = 7, PH_MULWAIT = 8, PH_ALUWB = 9,
                 PH_BRANCH = 10;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MulDone;
  logic        PCWrite, AdrSrc, MemW, IRWrite, RegW, ALUSrcA, MulStart;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;

  mc_control_unit #(.MUL_MAX_CYC(MUL_MAX)) dut (
    .CLK(CLK), .Reset(Reset), .Instr(Instr), .ALUFlags(ALUFlags), .MulDone(MulDone),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemW(MemW), .IRWrite(IRWrite), .RegW(RegW),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .ALUControl(ALUControl), .MulStart(MulStart)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] res;
    logic       srca;
    logic [1:0] srcb, imm, rsrc;
    logic [2:0] alu;
    logic       mst;
  } vec_t;

  typedef struct { vec_t v; vec_t m; int ph; } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [3:0]  nzcv_m;
  logic [31:0] ir;
  logic        force_en;
  logic [3:0]  force_val;
  logic [3:0]  cmds [6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0111, 4'b1110};

  function automatic string ph_name(input int p);
    case (p)
      PH_FETCH: return "FETCH";     PH_DECODE: return "DECODE";  PH_MEMADR: return "MEMADR";
      PH_MEMRD: return "MEMRD";     PH_MEMWB: return "MEMWB";    PH_MEMWR: return "MEMWR";
      PH_EXECR: return "EXECR";     PH_EXECI: return "EXECI";    PH_MULWAIT: return "MULWAIT";
      PH_ALUWB: return "ALUWB";     default: return "BRANCH";
    endcase
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;             4'h1: return !z;
      4'h2: return cy;            4'h3: return !cy;
      4'h4: return n;             4'h5: return !n;
      4'h6: return v;             4'h7: return !v;
      4'h8: return cy && !z;      4'h9: return !cy || z;
      4'hA: return n == v;        4'hB: return n != v;
      4'hC: return !z && n == v;  4'hD: return z || n != v;
      4'hE: return 1'b1;          default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 3'b000;  4'b0010: return 3'b001;
      4'b0000: return 3'b010;  4'b1100: return 3'b011;
      4'b0111: return 3'b100;  default: return 3'b101;
    endcase
  endfunction

  // Expected outputs for one cycle; fields the instruction leaves free are masked off.
  function automatic exp_t build(input int ph, input logic [31:0] ins);
    exp_t e;
    logic [1:0] op;
    op = ins[27:26];
    e.v = '0; e.m = '0; e.ph = ph;
    e.m.pcw = 1'b1; e.m.memw = 1'b1; e.m.irw = 1'b1; e.m.regw = 1'b1; e.m.mst = 1'b1;
    if (ph != PH_FETCH && op != 2'b11) begin
      e.m.imm = 2'b11; e.v.imm = op;
      case (op)
        2'b00:   begin e.v.rsrc = 2'b00; e.m.rsrc = ins[25] ? 2'b01 : 2'b11; end
        2'b01:   begin e.v.rsrc = ins[20] ? 2'b00 : 2'b10; e.m.rsrc = ins[20] ? 2'b01 : 2'b11; end
        default: begin e.v.rsrc = 2'b01; e.m.rsrc = 2'b01; end
      endcase
    end
    case (ph)
      PH_FETCH: begin
        e.v.pcw = 1; e.v.irw = 1; e.m.adr = 1; e.v.srca = 1; e.m.srca = 1;
        e.v.srcb = 2'b10; e.m.srcb = 2'b11; e.m.alu = 3'b111; e.v.res = 2'b10; e.m.res = 2'b11;
      end
      PH_DECODE: begin
        e.v.srca = 1; e.m.srca = 1; e.v.srcb = 2'b10; e.m.srcb = 2'b11; e.m.alu = 3'b111;
      end
      PH_MEMADR: begin
        e.m.srca = 1; e.v.srcb = 2'b01; e.m.srcb = 2'b11; e.m.alu = 3'b111;
      end
      PH_MEMRD: begin e.v.adr = 1; e.m.adr = 1; e.m.res = 2'b11; end
      PH_MEMWB: begin e.v.res = 2'b01; e.m.res = 2'b11; e.v.regw = 1; end
      PH_MEMWR: begin e.v.adr = 1; e.m.adr = 1; e.v.memw = 1; end
      PH_EXECR, PH_EXECI: begin
        e.m.srca = 1; e.v.srcb = (ph == PH_EXECI) ? 2'b01 : 2'b00; e.m.srcb = 2'b11;
        e.v.alu = alu_of(ins[24:21]); e.m.alu = 3'b111;
        e.v.mst = !ins[25] && (ins[24:21] == 4'b0111 || ins[24:21] == 4'b1110);
      end
      PH_MULWAIT: begin e.v.alu = alu_of(ins[24:21]); e.m.alu = 3'b111; end
      PH_ALUWB: begin e.m.res = 2'b11; e.v.regw = 1; end
      default: begin
        e.v.pcw = 1; e.m.srca = 1; e.v.srcb = 2'b01; e.m.srcb = 2'b11;
        e.m.alu = 3'b111; e.v.res = 2'b10; e.m.res = 2'b11;
      end
    endcase
    return e;
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic step(input int ph, input logic [31:0] ins, input logic md, output logic [3:0] fl);
    @(posedge CLK); #1;
    Reset = 1'b0; Instr = ins; MulDone = md;
    ALUFlags = force_en ? force_val : 4'($urandom);
    fl = ALUFlags;
    q.push_back(build(ph, ins));
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      Reset = 1'b1; MulDone = rbit(); ALUFlags = 4'($urandom);
    end
    nzcv_m = 4'b0000;
  endtask

  // One instruction from FETCH to its last cycle; d = MulDone delay after MulStart (0 = never).
  task automatic run_instr(input logic [31:0] ins, input int d);
    logic [3:0] fl;
    logic       is_mul, md;
    bit         done;
    int         n;
    step(PH_FETCH, ir, rbit(), fl);
    ir = ins;
    step(PH_DECODE, ins, rbit(), fl);
    if (ins[27:26] == 2'b11 || !cond_ok(ins[31:28], nzcv_m)) return;
    case (ins[27:26])
      2'b01: begin
        step(PH_MEMADR, ins, rbit(), fl);
        if (ins[20]) begin
          step(PH_MEMRD, ins, rbit(), fl);
          step(PH_MEMWB, ins, rbit(), fl);
        end else step(PH_MEMWR, ins, rbit(), fl);
      end
      2'b10: step(PH_BRANCH, ins, rbit(), fl);
      default: begin
        is_mul = !ins[25] && (ins[24:21] == 4'b0111 || ins[24:21] == 4'b1110);
        step(ins[25] ? PH_EXECI : PH_EXECR, ins, rbit(), fl);
        if (is_mul) begin
          n = 0; done = 0;
          while (!done) begin
            md = (d > 0) && (n == d - 1);
            step(PH_MULWAIT, ins, md, fl);
            done = md || (n == MUL_MAX - 1);
            n++;
          end
        end
        if (ins[20]) begin
          nzcv_m[3:2] = fl[3:2];
          if (ins[24:21] == 4'b0100 || ins[24:21] == 4'b0010) nzcv_m[1:0] = fl[1:0];
        end
        step(PH_ALUWB, ins, rbit(), fl);
      end
    endcase
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0] cond, cmd;
    logic       i;
    int         sel;
    cond = 4'($urandom);
    sel  = $urandom_range(0, 9);
    if (sel <= 4) begin
      cmd = cmds[$urandom_range(0, 5)];
      i   = (cmd == 4'b0111 || cmd == 4'b1110) ? 1'b0 : rbit();
      return {cond, 2'b00, i, cmd, rbit(), 20'($urandom)};
    end else if (sel <= 6) return {cond, 2'b01, 26'($urandom)};
    else if (sel <= 8)     return {cond, 2'b10, 26'($urandom)};
    else                   return {cond, 2'b11, 26'($urandom)};
  endfunction

  // Monitor: reset cycles must carry no enables; otherwise compare against the scoreboard.
  always @(negedge CLK) begin
    vec_t act;
    exp_t e;
    act = {PCWrite, AdrSrc, MemW, IRWrite, RegW, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegSrc, ALUControl, MulStart};
    if (Reset === 1'b1) begin
      total++;
      if ({PCWrite, IRWrite, RegW, MemW, MulStart} !== 5'b00000) begin
        bad++;
        $display("FAIL reset_enables: got %b required 00000 at %0t",
                 {PCWrite, IRWrite, RegW, MemW, MulStart}, $time);
      end
    end else if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (((act ^ e.v) & e.m) !== '0) begin
        bad++;
        $display("FAIL %s outputs: got %b required %b care %b at %0t",
                 ph_name(e.ph), act, e.v, e.m, $time);
      end
    end
  end

  initial begin
    Reset = 1'b1; Instr = '0; ALUFlags = '0; MulDone = 1'b0;
    ir = '0; nzcv_m = '0; force_en = 1'b0; force_val = '0;
    reset_cycles(3);

    force_en = 1'b1; force_val = 4'b0100;
    run_instr(32'hE0921003, 0);               // ADDS R1,R2,R3 -> Z set
    force_en = 1'b0;
    run_instr(32'h0A000000, 0);               // BEQ taken
    run_instr(32'h1A000000, 0);               // BNE falls through
    run_instr(32'hE5921000, 0);               // LDR
    run_instr(32'hE5821000, 0);               // STR
    run_instr(32'hE1C21003, 7);               // SMUL, MulDone 7 cycles after start
    run_instr(32'hE0E21003, 0);               // UMUL, watchdog expiry

    force_en = 1'b1; force_val = 4'b1111;
    run_instr(32'hE0921003, 0);               // ADDS sets all flags
    force_en = 1'b0;
    begin : abort_str
      logic [3:0] fl;
      step(PH_FETCH, ir, 1'b0, fl);
      ir = 32'hE5821000;
      step(PH_DECODE, ir, 1'b0, fl);
      reset_cycles(2);                        // reset lands in MEMADR
    end
    run_instr(32'h0A000000, 0);               // BEQ must not be taken: flags cleared
    run_instr(32'h2A000000, 0);               // BCS not taken
    run_instr(32'hFA000000, 0);               // cond 1111 never executes

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 39) == 0) reset_cycles($urandom_range(1, 2));
      run_instr(rand_instr(), $urandom_range(0, 40));
    end

    @(negedge CLK); #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
